// File: rtl/blink_set_controller_pkg.sv
// Shared mode encoding and digit-pair blank masks for the time-setting sequencer.
package blink_set_controller_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2,
        MODE_SET_SEC = 2'd3
    } mode_e;

    localparam logic [5:0] MASK_HR  = 6'b110000;
    localparam logic [5:0] MASK_MIN = 6'b001100;
    localparam logic [5:0] MASK_SEC = 6'b000011;

    function automatic logic [5:0] pairMask(input mode_e m);
        logic [5:0] mask;
        mask = 6'b000000;
        case (m)
            MODE_SET_HR:  mask = MASK_HR;
            MODE_SET_MIN: mask = MASK_MIN;
            MODE_SET_SEC: mask = MASK_SEC;
            default:      mask = 6'b000000;
        endcase
        return mask;
    endfunction

    function automatic mode_e nextMode(input mode_e m);
        mode_e n;
        n = MODE_RUN;
        case (m)
            MODE_RUN:     n = MODE_SET_HR;
            MODE_SET_HR:  n = MODE_SET_MIN;
            MODE_SET_MIN: n = MODE_SET_SEC;
            default:      n = MODE_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/flick_edge_timeout.sv
// Rising-edge detector on clkFlick plus a clearable edge counter that flags
// the edge completing LIMIT counted edges.
module flick_edge_timeout #(
    parameter int LIMIT = 60,
    parameter int TW    = 6
) (
    input  logic Clk,
    input  logic reset,
    input  logic clkFlick,
    input  logic countEn,
    input  logic clear,
    output logic flickRise,
    output logic timeoutHit
);

    logic          flickPrev_q;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          atLimit;

    assign flickRise  = clkFlick & ~flickPrev_q;
    assign atLimit    = (cnt_q == TW'(LIMIT - 1));
    // A clear in the same cycle masks the hit so button pulses win over timeout.
    assign timeoutHit = countEn & ~clear & flickRise & atLimit;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || timeoutHit) begin
            cnt_d = '0;
        end else if (countEn && flickRise) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            flickPrev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            flickPrev_q <= clkFlick;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/blink_set_controller.sv
// Time-setting sequencer: steps RUN/SET_HR/SET_MIN/SET_SEC, routes increment
// pulses, blinks the selected digit pair and auto-returns to RUN when idle.
module blink_set_controller
    import blink_set_controller_pkg::*;
#(
    parameter int TIMEOUT_EDGES = 60,
    parameter int TW            = 6,
    parameter int HOLD_EDGES    = 2
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       clkFlick,
    input  logic       btnMode,
    input  logic       btnInc,
    output logic [1:0] mode,
    output logic [5:0] blankMask,
    output logic       incHour,
    output logic       incMin,
    output logic       incSec
);

    localparam int HW = $clog2(HOLD_EDGES + 1);

    mode_e         mode_q, mode_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [5:0]    blankMask_q, blankMask_d;
    logic          incHour_q, incHour_d;
    logic          incMin_q, incMin_d;
    logic          incSec_q, incSec_d;

    logic inSet;
    logic incAccepted;
    logic timeoutClear;
    logic flickRise;
    logic timeoutHit;

    assign inSet        = (mode_q != MODE_RUN);
    assign incAccepted  = btnInc & ~btnMode & inSet;
    assign timeoutClear = btnMode | btnInc | ~inSet;

    flick_edge_timeout #(
        .LIMIT (TIMEOUT_EDGES),
        .TW    (TW)
    ) u_timeout (
        .Clk        (Clk),
        .reset      (reset),
        .clkFlick   (clkFlick),
        .countEn    (inSet),
        .clear      (timeoutClear),
        .flickRise  (flickRise),
        .timeoutHit (timeoutHit)
    );

    always_comb begin
        mode_d      = mode_q;
        hold_d      = hold_q;
        blankMask_d = 6'b000000;
        incHour_d   = 1'b0;
        incMin_d    = 1'b0;
        incSec_d    = 1'b0;

        if (btnMode) begin
            mode_d = nextMode(mode_q);
        end else if (timeoutHit) begin
            mode_d = MODE_RUN;
        end

        if (mode_d != mode_q) begin
            hold_d = '0;
        end else if (incAccepted) begin
            hold_d = HW'(HOLD_EDGES);
        end else if (flickRise && (hold_q != '0)) begin
            hold_d = hold_q - HW'(1);
        end

        // Digits stay visible while the hold counter runs after an increment.
        if (inSet && clkFlick && (hold_q == '0)) begin
            blankMask_d = pairMask(mode_q);
        end

        incHour_d = incAccepted & (mode_q == MODE_SET_HR);
        incMin_d  = incAccepted & (mode_q == MODE_SET_MIN);
        incSec_d  = incAccepted & (mode_q == MODE_SET_SEC);
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            mode_q      <= MODE_RUN;
            hold_q      <= '0;
            blankMask_q <= 6'b000000;
            incHour_q   <= 1'b0;
            incMin_q    <= 1'b0;
            incSec_q    <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            blankMask_q <= blankMask_d;
            incHour_q   <= incHour_d;
            incMin_q    <= incMin_d;
            incSec_q    <= incSec_d;
        end
    end

    assign mode      = mode_q;
    assign blankMask = blankMask_q;
    assign incHour   = incHour_q;
    assign incMin    = incMin_q;
    assign incSec    = incSec_q;

endmodule

// File: tb/tb_blink_set_controller.sv
// Randomized and directed bench for blink_set_controller against a rule-level
// model of the setting sequence, timeout and hold behaviour.
module tb_blink_set_controller;

    localparam int TO   = 4;
    localparam int HOLD = 2;

    logic       Clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       clkFlick = 1'b0;
    logic       btnMode  = 1'b0;
    logic       btnInc   = 1'b0;
    logic [1:0] mode;
    logic [5:0] blankMask;
    logic       incHour, incMin, incSec;

    int errors = 0;
    int checks = 0;

    int mMode = 0;
    int mTout = 0;
    int mHold = 0;
    bit mPrev = 1'b0;
    int eBlank = 0;
    bit eH = 1'b0, eM = 1'b0, eS = 1'b0;

    int phase = 0;
    bit lastRise = 1'b0;

    blink_set_controller #(
        .TIMEOUT_EDGES (TO),
        .TW            (6),
        .HOLD_EDGES    (HOLD)
    ) dut (
        .Clk       (Clk),
        .reset     (reset),
        .clkFlick  (clkFlick),
        .btnMode   (btnMode),
        .btnInc    (btnInc),
        .mode      (mode),
        .blankMask (blankMask),
        .incHour   (incHour),
        .incMin    (incMin),
        .incSec    (incSec)
    );

    always #5 Clk = ~Clk;

    // Which digit pair a SET state owns: hours 5:4, minutes 3:2, seconds 1:0.
    function automatic int pairMaskOf(input int md);
        case (md)
            1:       return 48;
            2:       return 12;
            3:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelClear();
        mMode = 0; mTout = 0; mHold = 0; mPrev = 1'b0;
        eBlank = 0; eH = 1'b0; eM = 1'b0; eS = 1'b0;
    endtask

    // One clock of the setting rules, given the inputs seen at that edge.
    task automatic modelStep(input bit m, input bit i, input bit f);
        bit rise;
        rise   = f && !mPrev;
        eBlank = (mMode != 0 && f && mHold == 0) ? pairMaskOf(mMode) : 0;
        eH = i && !m && (mMode == 1);
        eM = i && !m && (mMode == 2);
        eS = i && !m && (mMode == 3);
        if (m) begin
            mMode = (mMode + 1) % 4;
            mHold = 0;
            mTout = 0;
        end else if (i) begin
            if (mMode != 0) mHold = HOLD;
            mTout = 0;
        end else if (mMode != 0 && rise) begin
            if (mTout == TO - 1) begin
                mMode = 0; mTout = 0; mHold = 0;
            end else begin
                mTout++;
                if (mHold > 0) mHold--;
            end
        end
        mPrev = f;
    endtask

    task automatic compareAll();
        checkOutput("mode", mode, mMode);
        checkOutput("blankMask", blankMask, eBlank);
        checkOutput("incHour", incHour, eH);
        checkOutput("incMin", incMin, eM);
        checkOutput("incSec", incSec, eS);
    endtask

    task automatic applyStimulus(input bit m, input bit i);
        bit f;
        btnMode  = m;
        btnInc   = i;
        f        = clkFlick;
        lastRise = f && !mPrev && reset;
        @(posedge Clk);
        if (reset) modelStep(m, i, f);
        else       modelClear();
        #1;
        btnMode = 1'b0;
        btnInc  = 1'b0;
        phase++;
        if (phase % 8 == 0) clkFlick = ~clkFlick;
        compareAll();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic goRun();
        for (int k = 0; k < 4 && mMode != 0; k++) applyStimulus(1'b1, 1'b0);
    endtask

    function automatic bit nextRise();
        return clkFlick && !mPrev;
    endfunction

    initial begin
        int expSeq[4];
        int seenOn, seenOff, rises, n, held;
        bit done;
        expSeq[0] = 1; expSeq[1] = 2; expSeq[2] = 3; expSeq[3] = 0;

        #3;
        checkOutput("rstMode", mode, 0);
        checkOutput("rstBlank", blankMask, 0);
        checkOutput("rstInc", {incHour, incMin, incSec}, 0);
        modelClear();
        #9 reset = 1'b1;
        idle(20);

        // Mode cycling
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("cycMode", mode, expSeq[k]);
            checkOutput("cycInc", {incHour, incMin, incSec}, 0);
            idle(19);
        end

        // Increment routing
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("incMinPulse", incMin, 1);
        checkOutput("incHourQuiet", incHour, 0);
        checkOutput("incSecQuiet", incSec, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("incMinOnce", incMin, 0);
        goRun();
        checkOutput("runMode", mode, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("runIncDropped", {incHour, incMin, incSec}, 0);

        // Blink and hold in SET_HR
        applyStimulus(1'b1, 1'b0);
        seenOn = 0; seenOff = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 1'b0);
            if (blankMask == 6'b110000) seenOn++;
            if (blankMask == 6'b000000) seenOff++;
        end
        checkOutput("blinkOn", seenOn != 0, 1);
        checkOutput("blinkOff", seenOff != 0, 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("holdInc", incHour, 1);
        held = 0; rises = 0; n = 0;
        while (rises < 2 && n < 64) begin
            applyStimulus(1'b0, 1'b0);
            held = held | int'(blankMask);
            if (lastRise) rises++;
            n++;
        end
        checkOutput("holdBlank", held, 0);
        checkOutput("holdRises", rises, 2);
        applyStimulus(1'b0, 1'b0);
        checkOutput("holdResume", blankMask, 6'b110000);
        goRun();

        // Asynchronous reset while in SET_MIN with an inc pulse showing
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idle(5);
        applyStimulus(1'b0, 1'b1);
        checkOutput("preRstMode", mode, 2);
        checkOutput("preRstInc", incMin, 1);
        #2 reset = 1'b0;
        modelClear();
        #1;
        checkOutput("asyncMode", mode, 0);
        checkOutput("asyncBlank", blankMask, 0);
        checkOutput("asyncInc", {incHour, incMin, incSec}, 0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        reset = 1'b1;
        idle(40);
        checkOutput("postRstMode", mode, 0);

        // Timeout from SET_SEC with no buttons
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0);
        checkOutput("toEnter", mode, 3);
        rises = 0; n = 0;
        while (mode != 2'd0 && n < 200) begin
            applyStimulus(1'b0, 1'b0);
            if (lastRise) rises++;
            n++;
        end
        checkOutput("toReturn", mode, 0);
        checkOutput("toRises", rises, 4);

        // Timeout restarted by an inc on the 3rd edge
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0);
        rises = 0; n = 0; done = 1'b0;
        while (!done && n < 200) begin
            if (nextRise() && rises == 2) begin
                applyStimulus(1'b0, 1'b1);
                done = 1'b1;
            end else begin
                applyStimulus(1'b0, 1'b0);
                if (lastRise) rises++;
            end
            n++;
        end
        checkOutput("toIncMode", mode, 3);
        checkOutput("toIncPulse", incSec, 1);
        rises = 0; n = 0;
        while (mode != 2'd0 && n < 200) begin
            applyStimulus(1'b0, 1'b0);
            if (lastRise) rises++;
            n++;
        end
        checkOutput("toRestartReturn", mode, 0);
        checkOutput("toRestartRises", rises, 4);

        // Collisions
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("colMode", mode, 2);
        checkOutput("colNoInc", {incHour, incMin, incSec}, 0);
        goRun();
        applyStimulus(1'b1, 1'b0);
        rises = 0; n = 0; done = 1'b0;
        while (!done && n < 200) begin
            if (nextRise() && rises == 3) begin
                applyStimulus(1'b1, 1'b0);
                done = 1'b1;
            end else begin
                applyStimulus(1'b0, 1'b0);
                if (lastRise) rises++;
            end
            n++;
        end
        checkOutput("colToReached", done, 1);
        checkOutput("colToMode", mode, 2);
        goRun();

        // Random buttons against the model
        for (int k = 0; k < 2500; k++) begin
            applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
